vmx_sum_collector: RTL and testbench

//  Sits at the bottom of each PE column of the VMX systolic array and consumes the 32-bit

---
 rtl/vmx_pkg.sv | 24 ++
 rtl/vmx_sum_collector_if.sv | 22 ++
 rtl/vmx_sync_fifo.sv | 49 ++++
 rtl/vmx_sum_collector.sv | 103 ++++++++++
 tb/tb_vmx_sum_collector.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/vmx_pkg.sv
// Shared widths, mode encoding, FSM states and the requantise helper for the VMX column sum collector.
package vmx_pkg;
   localparam int SUM_W      = 32;
   localparam int ACC_W      = 40;
   localparam int OUT_W      = 16;
   localparam int FIFO_DEPTH = 8;
   localparam int SHIFT_W    = 5;

   localparam logic MODE_16B   = 1'b0;
   localparam logic MODE_SIMD8 = 1'b1;

   typedef enum logic {IDLE, ACCUM} state_e;

   // Round-half-up right shift, then clamp; MSB of the result flags a clamp.
   function automatic logic [OUT_W:0] requant(input logic [ACC_W-1:0] acc,
                                              input logic [SHIFT_W-1:0] sh);
      logic [ACC_W:0] rnd;
      logic [ACC_W:0] r;
      rnd = (sh == '0) ? '0 : ((ACC_W+1)'(1) << (sh - 1'b1));
      r   = ({1'b0, acc} + rnd) >> sh;
      if (r > (ACC_W+1)'(2**OUT_W - 1)) return {1'b1, {OUT_W{1'b1}}};
      return {1'b0, r[OUT_W-1:0]};
   endfunction
endpackage

// File: rtl/vmx_sum_collector_if.sv
// Beat-in / result-out / flag signals of one collector column.
interface vmx_sum_collector_if;
   import vmx_pkg::*;
   logic               simd_mode;
   logic               s_valid;
   logic               s_ready;
   logic               s_last;
   logic [SUM_W-1:0]   sum_in;
   logic [SHIFT_W-1:0] shift;
   logic [2*OUT_W-1:0] m_tdata;
   logic               m_tuser;
   logic               m_tvalid;
   logic               m_tready;
   logic               clr_flags;
   logic               sat_flag;
   logic               ovf_flag;

   modport slave (input simd_mode, s_valid, s_last, sum_in, shift, m_tready, clr_flags,
                  output s_ready, m_tdata, m_tuser, m_tvalid, sat_flag, ovf_flag);
   modport master (output simd_mode, s_valid, s_last, sum_in, shift, m_tready, clr_flags,
                   input s_ready, m_tdata, m_tuser, m_tvalid, sat_flag, ovf_flag);
endinterface

// File: rtl/vmx_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count.
module vmx_sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: rtl/vmx_sum_collector.sv
// Column-bottom collector: accumulates K-tile partial sums, requantises and queues results.
module vmx_sum_collector
   import vmx_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input logic               clk,
   input logic               rst_n,
   vmx_sum_collector_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int RQ_W  = 2*OUT_W + 1;

   state_e           state_q, state_d;
   logic             mode_q, mode_d, mode_eff;
   logic [ACC_W-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
   logic [ACC_W:0]   sum0, sum1;
   logic [ACC_W-1:0] lane0_in, lane1_in;
   logic [OUT_W:0]   q0, q1;
   logic [RQ_W-1:0]  rq_q, rq_d;
   logic             rq_vld_q;
   logic             sat_q, ovf_q, sat_set, ovf_set;
   logic             first, beat, s_ready;
   logic [CNT_W-1:0] fifo_cnt;
   logic [RQ_W-1:0]  fifo_rdata;
   logic             fifo_empty, fifo_full;

   // Reserve a slot for a result still sitting in the requant register.
   assign s_ready  = ((CNT_W+1)'(fifo_cnt) + (CNT_W+1)'(rq_vld_q)) < (CNT_W+1)'(DEPTH);
   assign beat     = bus.s_valid && s_ready;
   assign first    = (state_q == IDLE);
   assign mode_eff = first ? bus.simd_mode : mode_q;

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      acc0_d   = acc0_q;
      acc1_d   = acc1_q;
      rq_d     = rq_q;
      sat_set  = 1'b0;
      ovf_set  = 1'b0;
      q0       = '0;
      q1       = '0;
      lane0_in = (mode_eff == MODE_SIMD8) ? ACC_W'(bus.sum_in[15:0]) : ACC_W'(bus.sum_in);
      lane1_in = (mode_eff == MODE_SIMD8) ? ACC_W'(bus.sum_in[31:16]) : '0;
      // First beat of a group starts from zero so nothing carries over between groups.
      sum0     = (first ? '0 : {1'b0, acc0_q}) + {1'b0, lane0_in};
      sum1     = (first ? '0 : {1'b0, acc1_q}) + {1'b0, lane1_in};
      if (beat) begin
         acc0_d  = sum0[ACC_W-1:0];
         acc1_d  = sum1[ACC_W-1:0];
         ovf_set = sum0[ACC_W] | sum1[ACC_W];
         mode_d  = mode_eff;
         state_d = bus.s_last ? IDLE : ACCUM;
         if (bus.s_last) begin
            q0      = requant(sum0[ACC_W-1:0], bus.shift);
            if (mode_eff == MODE_SIMD8) q1 = requant(sum1[ACC_W-1:0], bus.shift);
            rq_d    = {mode_eff, q1[OUT_W-1:0], q0[OUT_W-1:0]};
            sat_set = q0[OUT_W] | q1[OUT_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mode_q   <= MODE_16B;
         acc0_q   <= '0;
         acc1_q   <= '0;
         rq_q     <= '0;
         rq_vld_q <= 1'b0;
         sat_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         acc0_q   <= acc0_d;
         acc1_q   <= acc1_d;
         rq_q     <= rq_d;
         rq_vld_q <= beat && bus.s_last;
         sat_q    <= sat_set | (sat_q & ~bus.clr_flags);
         ovf_q    <= ovf_set | (ovf_q & ~bus.clr_flags);
      end
   end

   vmx_sync_fifo #(.WIDTH(RQ_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (rq_vld_q),
      .wdata_i (rq_q),
      .pop_i   (bus.m_tready),
      .rdata_o (fifo_rdata),
      .count_o (fifo_cnt),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   assign bus.s_ready  = s_ready;
   assign bus.m_tvalid = !fifo_empty;
   assign {bus.m_tuser, bus.m_tdata} = fifo_empty ? '0 : fifo_rdata;
   assign bus.sat_flag = sat_q;
   assign bus.ovf_flag = ovf_q;
endmodule

// File: tb/tb_vmx_sum_collector.sv
// Directed bench for vmx_sum_collector with hand-computed expected results.
module tb_vmx_sum_collector;
   import vmx_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   vmx_sum_collector_if bus ();

   vmx_sum_collector dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] d, input logic last);
      int n = 0;
      bus.s_valid = 1'b1;
      bus.sum_in  = d;
      bus.s_last  = last;
      while (!bus.s_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.s_ready) chk("send_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] d, input logic u);
      int n = 0;
      while (!bus.m_tvalid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_vld"}, 64'(bus.m_tvalid), 64'd1);
      chk({tag, "_data"}, 64'(bus.m_tdata), 64'(d));
      chk({tag, "_user"}, 64'(bus.m_tuser), 64'(u));
      bus.m_tready = 1'b1;
      @(posedge clk); #1;
      bus.m_tready = 1'b0;
   endtask

   task automatic clr();
      bus.clr_flags = 1'b1;
      @(posedge clk); #1;
      bus.clr_flags = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      bus.simd_mode = 1'b0;
      bus.s_valid   = 1'b0;
      bus.s_last    = 1'b0;
      bus.sum_in    = '0;
      bus.shift     = '0;
      bus.m_tready  = 1'b0;
      bus.clr_flags = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tvalid", 64'(bus.m_tvalid), 64'd0);
      chk("rst_tdata",  64'(bus.m_tdata),  64'd0);
      chk("rst_tuser",  64'(bus.m_tuser),  64'd0);
      chk("rst_sready", 64'(bus.s_ready),  64'd1);
      chk("rst_sat",    64'(bus.sat_flag), 64'd0);
      chk("rst_ovf",    64'(bus.ovf_flag), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 16-bit accumulate, latency of two edges after the last beat
      send(32'd100, 1'b0);
      send(32'd200, 1'b0);
      send(32'd300, 1'b1);
      chk("t1_lat_e0", 64'(bus.m_tvalid), 64'd0);
      @(posedge clk); #1;
      chk("t1_lat_e1", 64'(bus.m_tvalid), 64'd1);
      pop_chk("t1", 32'h0000_0258, 1'b0);

      // SIMD with rounding; mode change mid-group must be ignored
      bus.simd_mode = 1'b1;
      bus.shift     = 5'd1;
      send({16'd10, 16'd20}, 1'b0);
      bus.simd_mode = 1'b0;
      send({16'd10, 16'd20}, 1'b1);
      pop_chk("t2", 32'h000A_0014, 1'b1);

      // saturation and flag clear
      bus.shift = 5'd0;
      send(32'h0001_0000, 1'b1);
      pop_chk("t3", 32'h0000_FFFF, 1'b0);
      chk("t3_sat_set", 64'(bus.sat_flag), 64'd1);
      clr();
      chk("t3_sat_clr", 64'(bus.sat_flag), 64'd0);

      // backpressure: FIFO plus requant slot fill after 8 results
      for (int i = 1; i <= 8; i++) send(32'(i), 1'b1);
      chk("t4_full", 64'(bus.s_ready), 64'd0);
      bus.s_valid = 1'b1;
      bus.sum_in  = 32'd9;
      bus.s_last  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t4_hold", 64'(bus.s_ready), 64'd0);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      for (int i = 1; i <= 8; i++) pop_chk($sformatf("t4_%0d", i), 32'(i), 1'b0);
      chk("t4_empty", 64'(bus.m_tvalid), 64'd0);
      send(32'd9, 1'b1);
      pop_chk("t4_9", 32'd9, 1'b0);

      // reset mid-group discards the partial sum
      send(32'd7, 1'b0);
      send(32'd7, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_sready", 64'(bus.s_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(32'd5, 1'b1);
      pop_chk("t5", 32'd5, 1'b0);

      // round-half-up on the shift
      bus.shift = 5'd2;
      send(32'd6, 1'b1);
      pop_chk("t6_6", 32'd2, 1'b0);
      send(32'd5, 1'b1);
      pop_chk("t6_5", 32'd1, 1'b0);

      // 40 full-scale beats stay inside 40 bits but clamp the output
      bus.shift = 5'd0;
      for (int i = 0; i < 39; i++) send(32'hFFFF_FFFF, 1'b0);
      send(32'hFFFF_FFFF, 1'b1);
      pop_chk("t6_big", 32'h0000_FFFF, 1'b0);
      chk("t6_ovf", 64'(bus.ovf_flag), 64'd0);
      chk("t6_sat", 64'(bus.sat_flag), 64'd1);

      // SIMD upper lane saturates, lower lane does not
      clr();
      chk("t7_pre_sat", 64'(bus.sat_flag), 64'd0);
      bus.simd_mode = 1'b1;
      send({16'hFFFF, 16'h0001}, 1'b0);
      send({16'hFFFF, 16'h0001}, 1'b1);
      pop_chk("t7", 32'hFFFF_0002, 1'b1);
      chk("t7_sat", 64'(bus.sat_flag), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
